// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial arbiter for the core's single 8-bit RAM port.
// Serves IF fetches (always 4 bytes) and MEM loads/stores (1/2/4 bytes),
// MEM first when both ask. A redirect (jmp_e) abandons a fetch in flight.
// Optional IO_BUF_FULL_EN: stores at or above IO_BASE wait while the UART
// TX buffer is full; without it io_buffer_full is ignored.
module mem_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jmp_e,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full,
  output logic              if_stall_req,
  output logic              mem_stall_req
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q;
  logic              owner_if_q;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        len_q;
  logic [2:0]        cnt_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;
  logic              got_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic [1:0]        cap_lane;
  logic [1:0]        nxt_lane;
  logic [ADDR_W-1:0] nxt_addr;
  logic              io_wait;

  // Lane being captured, next lane to drive and next byte address.
  always_comb begin
    cap_lane = 2'(cnt_q - 3'd1);
    nxt_lane = 2'(cnt_q + 3'd1);
    nxt_addr = base_q + ADDR_W'(cnt_q + 3'd1);
  end

`ifdef IO_BUF_FULL_EN
  assign io_wait = (state_q == S_WRITE) && (ram_a_q >= IO_BASE) && io_buffer_full;
`else
  logic unused_io;
  assign io_wait   = 1'b0;
  assign unused_io = io_buffer_full ^ (|IO_BASE);
`endif

  // Transaction FSM: accepts a request, walks the bytes, pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_if_q <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      got_q      <= 1'b0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else if (!rdy) begin
      // The RAM keeps answering the held address while frozen, so the byte
      // for the previous address is only on ram_din in the first frozen
      // cycle: keep it now and skip the normal capture on resume.
      if (state_q == S_READ && cnt_q != 3'd0 && !got_q) begin
        rbuf_q[{cap_lane, 3'b000} +: 8] <= ram_din;
        got_q                           <= 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          got_q      <= 1'b0;
          cnt_q      <= '0;
          rbuf_q     <= '0;
          if (mem_req) begin
            owner_if_q <= 1'b0;
            base_q     <= mem_addr;
            len_q      <= mem_len;
            wdata_q    <= mem_wdata;
            ram_a_q    <= mem_addr;
            if (mem_we) begin
              ram_dout_q <= mem_wdata[7:0];
              ram_wr_q   <= 1'b1;
              state_q    <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end else if (if_req && !jmp_e) begin
            owner_if_q <= 1'b1;
            base_q     <= if_addr;
            len_q      <= 3'd4;
            ram_a_q    <= if_addr;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (owner_if_q && jmp_e) begin
            got_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (cnt_q != 3'd0 && !got_q) begin
              rbuf_q[{cap_lane, 3'b000} +: 8] <= ram_din;
            end
            got_q <= 1'b0;
            if (cnt_q == len_q) begin
              if_done_q  <= owner_if_q;
              mem_done_q <= !owner_if_q;
              state_q    <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if ((cnt_q + 3'd1) < len_q) begin
                ram_a_q <= nxt_addr;
              end
            end
          end
        end
        S_WRITE: begin
          if (!io_wait) begin
            if ((cnt_q + 3'd1) < len_q) begin
              cnt_q      <= cnt_q + 3'd1;
              ram_a_q    <= nxt_addr;
              ram_dout_q <= wdata_q[{nxt_lane, 3'b000} +: 8];
            end else begin
              ram_wr_q   <= 1'b0;
              mem_done_q <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A redirect during the fetch's done cycle kills the pulse.
  assign if_done       = if_done_q & ~jmp_e;
  assign mem_done      = mem_done_q;
  assign if_data       = rbuf_q;
  assign mem_rdata     = rbuf_q;
  assign ram_a         = ram_a_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = ram_wr_q & rdy & ~io_wait;
  assign if_stall_req  = if_req & ~if_done;
  assign mem_stall_req = mem_req & ~mem_done;

endmodule
